// File: rtl/count_sequencer_pkg.sv
// Shared types and constants for the two-requester count sequencer.
// No logic; state encoding, requester count and default counter width.
package count_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_REQ       = 2;
    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/count_sequencer_if.sv
// Requester-side bus of the count sequencer: job requests, per-requester load/limit values, status.
// Pure wiring; requesters hold req until done or abort, no other flow control.
interface count_sequencer_if
    import count_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [NUM_REQ-1:0] req;
    logic [WIDTH-1:0]   start0;
    logic [WIDTH-1:0]   start1;
    logic [WIDTH-1:0]   limit0;
    logic [WIDTH-1:0]   limit1;
    logic [NUM_REQ-1:0] grant;
    logic               busy;
    logic               done;
    logic               done_id;
    logic [WIDTH-1:0]   A;

    modport master (
        output req, start0, start1, limit0, limit1,
        input  grant, busy, done, done_id, A
    );

    modport slave (
        input  req, start0, start1, limit0, limit1,
        output grant, busy, done, done_id, A
    );
endinterface

// File: rtl/count_sequencer_counter.sv
// Up-counter with synchronous clear and parallel load (priority clear > load > increment).
// One-cycle update latency; carry flags the all-ones to zero rollover of an increment.
module CounterWithParallelLoad
    import count_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic             increment,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] A,
    output logic             output_carry
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = data_in;
        end else if (increment) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        count_q <= count_d;
    end

    assign A            = count_q;
    assign output_carry = increment & (&count_q);

endmodule

// File: rtl/count_sequencer.sv
// Round-robin arbiter + FSM running one count job from start to limit; req->grant 1 cycle, done at 3+(limit-start).
// Owner dropping req aborts the job; optional sticky wrap flag under COUNT_SEQ_WRAP_FLAG_EN.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clock,
    input  logic              clear,
    count_sequencer_if.slave  bus
`ifdef COUNT_SEQ_WRAP_FLAG_EN
    ,
    output logic              wrapped
`endif
);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               owner_q, owner_d;
    logic               ptr_q, ptr_d;

    logic               winner;
    logic               owner_req;
    logic [WIDTH-1:0]   sel_start;
    logic [WIDTH-1:0]   sel_limit;
    logic [WIDTH-1:0]   cnt_val;
    logic               cnt_clr;
    logic               cnt_load;
    logic               cnt_inc;
    logic               cnt_carry;

    // Contention resolves to the pointer; otherwise whichever single bit is set.
    assign winner    = (bus.req[0] & bus.req[1]) ? ptr_q : bus.req[1];
    assign owner_req = bus.req[owner_q];
    assign sel_start = owner_q ? bus.start1 : bus.start0;
    assign sel_limit = owner_q ? bus.limit1 : bus.limit0;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    owner_d = winner;
                    grant_d = NUM_REQ'(1) << winner;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!owner_req) begin
                    cnt_clr = 1'b1;
                    grant_d = '0;
                    ptr_d   = ~owner_q;
                    state_d = IDLE;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = COUNT;
                end
            end
            COUNT: begin
                if (!owner_req) begin
                    cnt_clr = 1'b1;
                    grant_d = '0;
                    ptr_d   = ~owner_q;
                    state_d = IDLE;
                end else if (cnt_val == sel_limit) begin
                    grant_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                ptr_d   = ~owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    CounterWithParallelLoad #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clock        (clock),
        .clear        (clear | cnt_clr),
        .load         (cnt_load),
        .increment    (cnt_inc),
        .data_in      (sel_start),
        .A            (cnt_val),
        .output_carry (cnt_carry)
    );

    assign bus.grant   = grant_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.done_id = (state_q == DONE) & owner_q;
    assign bus.A       = cnt_val;

`ifdef COUNT_SEQ_WRAP_FLAG_EN
    logic wrapped_q, wrapped_d;

    always_comb begin
        wrapped_d = wrapped_q;
        if (state_q == LOAD) begin
            wrapped_d = 1'b0;
        end else if ((state_q == COUNT) && cnt_carry) begin
            wrapped_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            wrapped_q <= 1'b0;
        end else begin
            wrapped_q <= wrapped_d;
        end
    end

    assign wrapped = wrapped_q;
`else
    logic unused_carry;
    assign unused_carry = cnt_carry;
`endif

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: reset, normal jobs, round robin, wrap, start==limit, abort, mid-job clear.
module tb_count_sequencer;

    logic clock;
    logic clear;
    int   tests;
    int   fails;

    count_sequencer_if #(.WIDTH(4)) bus ();

`ifdef COUNT_SEQ_WRAP_FLAG_EN
    logic wrapped;
    count_sequencer #(.WIDTH(4)) dut (
        .clock   (clock),
        .clear   (clear),
        .bus     (bus),
        .wrapped (wrapped)
    );
`else
    count_sequencer #(.WIDTH(4)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, required %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clear = 1'b1;
        bus.req = 2'b00;
        bus.start0 = 4'd0; bus.limit0 = 4'd0;
        bus.start1 = 4'd0; bus.limit1 = 4'd0;
        step();
        step();
        chk("rst_grant",   32'(bus.grant),   32'd0);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_done",    32'(bus.done),    32'd0);
        chk("rst_done_id", 32'(bus.done_id), 32'd0);
        chk("rst_A",       32'(bus.A),       32'd0);

        // Lone requester 0, start 2 limit 6
        clear = 1'b0;
        bus.start0 = 4'd2; bus.limit0 = 4'd6; bus.req = 2'b01;
        step();
        chk("j1_grant", 32'(bus.grant), 32'h1);
        chk("j1_busy",  32'(bus.busy),  32'd1);
        for (int v = 2; v <= 6; v++) begin
            step();
            chk("j1_A",    32'(bus.A),    32'(v));
            chk("j1_nodn", 32'(bus.done), 32'd0);
        end
        step();
        chk("j1_done",    32'(bus.done),    32'd1);
        chk("j1_done_id", 32'(bus.done_id), 32'd0);
        chk("j1_grant0",  32'(bus.grant),   32'd0);
        bus.req = 2'b00;
        step();
        chk("j1_idle_done", 32'(bus.done), 32'd0);
        chk("j1_idle_busy", 32'(bus.busy), 32'd0);

        // start == limit: zero increments
        bus.start0 = 4'd5; bus.limit0 = 4'd5; bus.req = 2'b01;
        step();
        chk("eq_grant", 32'(bus.grant), 32'h1);
        step();
        chk("eq_A",    32'(bus.A),    32'd5);
        chk("eq_nodn", 32'(bus.done), 32'd0);
        step();
        chk("eq_done", 32'(bus.done), 32'd1);
        chk("eq_A2",   32'(bus.A),    32'd5);
        bus.req = 2'b00;
        step();

        // Round robin after reset: both request, 0 first, then 1
        clear = 1'b1;
        step();
        clear = 1'b0;
        bus.start0 = 4'd3; bus.limit0 = 4'd4;
        bus.start1 = 4'd7; bus.limit1 = 4'd7;
        bus.req = 2'b11;
        step();
        chk("rr_grant0", 32'(bus.grant), 32'h1);
        step();
        chk("rr_A3", 32'(bus.A), 32'd3);
        step();
        chk("rr_A4", 32'(bus.A), 32'd4);
        step();
        chk("rr_done0", 32'(bus.done),    32'd1);
        chk("rr_id0",   32'(bus.done_id), 32'd0);
        step();
        chk("rr_gap_grant", 32'(bus.grant), 32'd0);
        chk("rr_gap_busy",  32'(bus.busy),  32'd0);
        step();
        chk("rr_grant1", 32'(bus.grant), 32'h2);
        step();
        chk("rr_A7", 32'(bus.A), 32'd7);
        step();
        chk("rr_done1", 32'(bus.done),    32'd1);
        chk("rr_id1",   32'(bus.done_id), 32'd1);
        bus.req = 2'b00;
        step();

        // Wrap: requester 1, start 14 limit 1
        bus.start1 = 4'd14; bus.limit1 = 4'd1; bus.req = 2'b10;
        step();
        chk("wr_grant", 32'(bus.grant), 32'h2);
        step();
        chk("wr_A14", 32'(bus.A), 32'd14);
`ifdef COUNT_SEQ_WRAP_FLAG_EN
        chk("wr_flag0", 32'(wrapped), 32'd0);
`endif
        step();
        chk("wr_A15", 32'(bus.A), 32'd15);
        step();
        chk("wr_A0", 32'(bus.A), 32'd0);
        step();
        chk("wr_A1", 32'(bus.A), 32'd1);
        step();
        chk("wr_done", 32'(bus.done),    32'd1);
        chk("wr_id",   32'(bus.done_id), 32'd1);
`ifdef COUNT_SEQ_WRAP_FLAG_EN
        chk("wr_flag1", 32'(wrapped), 32'd1);
`endif
        bus.req = 2'b00;
        step();

        // Abort: owner 0 drops req at A=4, requester 1 then served
        clear = 1'b1;
        step();
        clear = 1'b0;
        bus.start0 = 4'd2; bus.limit0 = 4'd9;
        bus.start1 = 4'd5; bus.limit1 = 4'd6;
        bus.req = 2'b11;
        step();
        chk("ab_grant0", 32'(bus.grant), 32'h1);
        step();
        step();
        step();
        chk("ab_A4", 32'(bus.A), 32'd4);
        bus.req = 2'b10;
        step();
        chk("ab_A0",    32'(bus.A),     32'd0);
        chk("ab_grant", 32'(bus.grant), 32'd0);
        chk("ab_nodn",  32'(bus.done),  32'd0);
        chk("ab_busy",  32'(bus.busy),  32'd0);
        step();
        chk("ab_grant1", 32'(bus.grant), 32'h2);
        step();
        chk("ab_A5", 32'(bus.A), 32'd5);
        step();
        chk("ab_A6", 32'(bus.A), 32'd6);
        step();
        chk("ab_done", 32'(bus.done),    32'd1);
        chk("ab_id",   32'(bus.done_id), 32'd1);
        bus.req = 2'b00;
        step();

        // Short job by 0 so the pointer favours 1, then clear mid-job of 1
        bus.start0 = 4'd1; bus.limit0 = 4'd1; bus.req = 2'b01;
        step();
        step();
        step();
        chk("pre_done", 32'(bus.done), 32'd1);
        bus.req = 2'b00;
        step();
        bus.start0 = 4'd3; bus.limit0 = 4'd3;
        bus.start1 = 4'd7; bus.limit1 = 4'd12;
        bus.req = 2'b11;
        step();
        chk("cl_grant1", 32'(bus.grant), 32'h2);
        step();
        step();
        step();
        chk("cl_A9", 32'(bus.A), 32'd9);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("cl_A0",    32'(bus.A),     32'd0);
        chk("cl_busy",  32'(bus.busy),  32'd0);
        chk("cl_grant", 32'(bus.grant), 32'd0);
        chk("cl_done",  32'(bus.done),  32'd0);
        step();
        chk("cl_rearb", 32'(bus.grant), 32'h1);
        step();
        chk("cl_A3", 32'(bus.A), 32'd3);
        step();
        chk("cl_fin",    32'(bus.done),    32'd1);
        chk("cl_fin_id", 32'(bus.done_id), 32'd0);
        bus.req = 2'b00;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
